// File: rtl/multicycle_control32.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the Minisys MIPS32 datapath, with a retired-instruction counter.
// Optional memory handshake with timeout: define MEM_HANDSHAKE_EN.
module multicycle_control32 #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Function_opcode,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                Branch,
  output logic                nBranch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic [1:0]          reg_dst,
  output logic                ALUSrc,
  output logic [1:0]          ALUOp,
  output logic                I_format,
  output logic                Sftmd,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                retire,
  output logic [RETIRE_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_cnt_q, retired_cnt_d;
  logic                mem_done_s, timeout_s;
  logic is_rtype_s, is_jr_s, is_j_s, is_jal_s, is_beq_s, is_bne_s, is_ifmt_s, is_lw_s, is_sw_s, legal_s;

  assign is_rtype_s = (Opcode == 6'h00);
  assign is_jr_s    = is_rtype_s && (Function_opcode == 6'h08);
  assign is_j_s     = (Opcode == 6'h02);
  assign is_jal_s   = (Opcode == 6'h03);
  assign is_beq_s   = (Opcode == 6'h04);
  assign is_bne_s   = (Opcode == 6'h05);
  assign is_ifmt_s  = (Opcode[5:3] == 3'b001);
  assign is_lw_s    = (Opcode == 6'h23);
  assign is_sw_s    = (Opcode == 6'h2B);
  assign legal_s    = is_rtype_s | is_j_s | is_jal_s | is_beq_s | is_bne_s | is_ifmt_s | is_lw_s | is_sw_s;

`ifdef MEM_HANDSHAKE_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  assign mem_done_s = mem_ready;
  // A zero timeout means wait for mem_ready indefinitely.
  assign timeout_s  = (MEM_TIMEOUT != 32'sd0) && (wait_cnt_q == 16'(MEM_TIMEOUT)) && !mem_ready;

  // Wait counter restarts on every state entry, including IF re-entry after a timeout.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || timeout_s) begin
      wait_cnt_d = 16'd0;
    end else if (wait_cnt_q == 16'hFFFF) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end
`else
  logic mem_ready_unused_s;
  assign mem_ready_unused_s = mem_ready;
  assign mem_done_s         = 1'b1;
  assign timeout_s          = 1'b0;
`endif

  // Next state plus the state/IR-decoded control strobes; everything is forced low during reset.
  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    Branch    = 1'b0;
    nBranch   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    reg_dst   = 2'b00;
    illegal   = 1'b0;
    retire    = 1'b0;
    if (reset) begin
      state_d = S_IF;
    end else begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_done_s) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
          end else if (timeout_s) begin
            illegal = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_IF;
          end
        end
        S_ID: begin
          if (is_j_s || is_jal_s) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            RegWrite = is_jal_s;
            reg_dst  = is_jal_s ? 2'b10 : 2'b00;
            retire   = 1'b1;
            state_d  = S_IF;
          end else if (is_jr_s) begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
            retire   = 1'b1;
            state_d  = S_IF;
          end else if (legal_s) begin
            state_d = S_EX;
          end else begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        end
        S_EX: begin
          if (is_beq_s || is_bne_s) begin
            Branch  = is_beq_s;
            nBranch = is_bne_s;
            pc_src  = 2'b01;
            retire  = 1'b1;
            state_d = S_IF;
          end else if (is_lw_s || is_sw_s) begin
            state_d = S_MEM;
          end else if (is_rtype_s || is_ifmt_s) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
          end
        end
        S_MEM: begin
          mem_read  = is_lw_s;
          mem_write = is_sw_s;
          if (mem_done_s) begin
            if (is_sw_s) begin
              retire  = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end else if (timeout_s) begin
            mem_write = 1'b0;
            illegal   = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          reg_dst  = is_rtype_s ? 2'b01 : 2'b00;
          MemtoReg = is_lw_s;
          retire   = 1'b1;
          state_d  = S_IF;
        end
        default: begin
          state_d = S_IF;
        end
      endcase
    end
  end

  // ALU controls stay valid from EX through write-back so the result path is stable.
  always_comb begin
    ALUOp    = 2'b00;
    ALUSrc   = 1'b0;
    I_format = 1'b0;
    Sftmd    = 1'b0;
    if (!reset && ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB))) begin
      if (is_rtype_s) begin
        ALUOp = 2'b10;
        Sftmd = (Function_opcode[5:3] == 3'b000);
      end else if (is_ifmt_s) begin
        ALUOp    = 2'b10;
        ALUSrc   = 1'b1;
        I_format = 1'b1;
      end else if (is_lw_s || is_sw_s) begin
        ALUSrc = 1'b1;
      end else if (is_beq_s || is_bne_s) begin
        ALUOp = 2'b01;
      end else begin
        ALUOp = 2'b00;
      end
    end else begin
      ALUOp = 2'b00;
    end
  end

  assign retired_cnt_d = retired_cnt_q + {{(RETIRE_W-1){1'b0}}, retire};

  // Sequencer state, retired counter and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IF;
      retired_cnt_q <= {RETIRE_W{1'b0}};
`ifdef MEM_HANDSHAKE_EN
      wait_cnt_q    <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
`ifdef MEM_HANDSHAKE_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign state       = state_q;
  assign retired_cnt = retired_cnt_q;

endmodule
